// File: rtl/adam_kbd_fifo.sv
// -----------------------------------------------------------------------------
// adam_kbd_fifo
//   Turns raw PS/2 event words into ADAM keyboard character codes and buffers
//   them for the AdamNet keyboard device. The design tracks modifier state
//   (shift, ctrl, caps lock) and suppresses typematic repeats. Codes pass
//   through a three-stage pipeline into a circular FIFO that the consumer
//   drains with a valid/ready handshake.
//
// Parameters
//   DEPTH_LOG2     FIFO depth is 2**DEPTH_LOG2 entries
//   TYPEMATIC      1: repeated makes of a held key enqueue again; 0: dropped
//
// Ports
//   clk_i          system clock
//   reset_n_i      asynchronous active-low reset
//   ps2_key        [7:0] scancode, [8] extended, [9] pressed, [10] event toggle
//   key_data_o     ADAM code at the FIFO head (0 while empty)
//   key_valid_o    FIFO non-empty
//   key_ready_i    consumer accepts the head entry
//   overflow_o     sticky flag: a code was dropped because the FIFO was full
//   overflow_clr_i clears overflow_o
//   level_o        current FIFO occupancy
// -----------------------------------------------------------------------------
module adam_kbd_fifo #(
  parameter int DEPTH_LOG2 = 4,
  parameter int TYPEMATIC  = 0
) (
  input  logic                  clk_i,
  input  logic                  reset_n_i,
  input  logic [10:0]           ps2_key,
  output logic [7:0]            key_data_o,
  output logic                  key_valid_o,
  input  logic                  key_ready_i,
  output logic                  overflow_o,
  input  logic                  overflow_clr_i,
  output logic [DEPTH_LOG2:0]   level_o
);

  localparam int                 DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL_LVL = (DEPTH_LOG2 + 1)'(DEPTH);

  // ---------------------------------------------------------------------------
  // Stage 0: event detect and capture
  // ---------------------------------------------------------------------------
  logic       r_tog;
  logic       r_armed;     // low until the toggle copy holds a real sample
  logic       r_s1_vld;
  logic [9:0] r_s1_word;
  logic       w_event;

  // After reset the toggle copy is only trusted once it has sampled the input
  // level, so a stale ps2_key[10] never looks like a fresh event.
  assign w_event = r_armed & (ps2_key[10] ^ r_tog);

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_tog     <= 1'b0;
      r_armed   <= 1'b0;
      r_s1_vld  <= 1'b0;
      r_s1_word <= '0;
    end else begin
      r_tog    <= ps2_key[10];
      r_armed  <= 1'b1;
      r_s1_vld <= w_event;
      if (w_event) begin
        r_s1_word <= ps2_key[9:0];
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 1: translation, modifier tracking, repeat suppression
  // ---------------------------------------------------------------------------
  logic       r_shift_l;
  logic       r_shift_r;
  logic       r_ctrl;
  logic       r_caps;
  logic [8:0] r_held;
  logic       r_held_vld;
  logic       r_s2_vld;
  logic [7:0] r_s2_code;

  logic       w_s1_press;
  logic       w_s1_ext;
  logic [7:0] w_s1_code;
  logic [8:0] w_s1_key;
  logic       w_shift;
  logic       w_is_lshift;
  logic       w_is_rshift;
  logic       w_is_ctrl;
  logic       w_is_caps;
  logic       w_is_mod;
  logic       w_repeat;
  logic       w_s1_push;

  assign w_s1_press  = r_s1_word[9];
  assign w_s1_ext    = r_s1_word[8];
  assign w_s1_code   = r_s1_word[7:0];
  assign w_s1_key    = r_s1_word[8:0];
  assign w_shift     = r_shift_l | r_shift_r;

  // Shift and caps lock are only recognised without the E0 prefix; ctrl
  // covers both the left (14) and right (E0 14) keys.
  assign w_is_lshift = ~w_s1_ext & (w_s1_code == 8'h12);
  assign w_is_rshift = ~w_s1_ext & (w_s1_code == 8'h59);
  assign w_is_ctrl   = (w_s1_code == 8'h14);
  assign w_is_caps   = ~w_s1_ext & (w_s1_code == 8'h58);
  assign w_is_mod    = w_is_lshift | w_is_rshift | w_is_ctrl | w_is_caps;

  assign w_repeat    = (TYPEMATIC == 0) & r_held_vld & (r_held == w_s1_key);

  // Letter scancode -> alphabet index (A=0 .. Z=25)
  logic       w_letter_hit;
  logic [4:0] w_letter_idx;
  always_comb begin
    w_letter_hit = 1'b1;
    w_letter_idx = 5'd0;
    case (w_s1_code)
      8'h1C: w_letter_idx = 5'd0;
      8'h32: w_letter_idx = 5'd1;
      8'h21: w_letter_idx = 5'd2;
      8'h23: w_letter_idx = 5'd3;
      8'h24: w_letter_idx = 5'd4;
      8'h2B: w_letter_idx = 5'd5;
      8'h34: w_letter_idx = 5'd6;
      8'h33: w_letter_idx = 5'd7;
      8'h43: w_letter_idx = 5'd8;
      8'h3B: w_letter_idx = 5'd9;
      8'h42: w_letter_idx = 5'd10;
      8'h4B: w_letter_idx = 5'd11;
      8'h3A: w_letter_idx = 5'd12;
      8'h31: w_letter_idx = 5'd13;
      8'h44: w_letter_idx = 5'd14;
      8'h4D: w_letter_idx = 5'd15;
      8'h15: w_letter_idx = 5'd16;
      8'h2D: w_letter_idx = 5'd17;
      8'h1B: w_letter_idx = 5'd18;
      8'h2C: w_letter_idx = 5'd19;
      8'h3C: w_letter_idx = 5'd20;
      8'h2A: w_letter_idx = 5'd21;
      8'h1D: w_letter_idx = 5'd22;
      8'h22: w_letter_idx = 5'd23;
      8'h35: w_letter_idx = 5'd24;
      8'h1A: w_letter_idx = 5'd25;
      default: w_letter_hit = 1'b0;
    endcase
  end

  // Digit scancode -> digit value and its US-layout shifted character
  logic       w_digit_hit;
  logic [3:0] w_digit_idx;
  logic [7:0] w_digit_sh;
  always_comb begin
    w_digit_hit = 1'b1;
    w_digit_idx = 4'd0;
    w_digit_sh  = 8'h00;
    case (w_s1_code)
      8'h45: begin w_digit_idx = 4'd0; w_digit_sh = 8'h29; end
      8'h16: begin w_digit_idx = 4'd1; w_digit_sh = 8'h21; end
      8'h1E: begin w_digit_idx = 4'd2; w_digit_sh = 8'h40; end
      8'h26: begin w_digit_idx = 4'd3; w_digit_sh = 8'h23; end
      8'h25: begin w_digit_idx = 4'd4; w_digit_sh = 8'h24; end
      8'h2E: begin w_digit_idx = 4'd5; w_digit_sh = 8'h25; end
      8'h36: begin w_digit_idx = 4'd6; w_digit_sh = 8'h5E; end
      8'h3D: begin w_digit_idx = 4'd7; w_digit_sh = 8'h26; end
      8'h3E: begin w_digit_idx = 4'd8; w_digit_sh = 8'h2A; end
      8'h46: begin w_digit_idx = 4'd9; w_digit_sh = 8'h28; end
      default: w_digit_hit = 1'b0;
    endcase
  end

  // F1..F6 -> smart key index 0..5
  logic       w_fkey_hit;
  logic [2:0] w_fkey_idx;
  always_comb begin
    w_fkey_hit = 1'b1;
    w_fkey_idx = 3'd0;
    case (w_s1_code)
      8'h05: w_fkey_idx = 3'd0;
      8'h06: w_fkey_idx = 3'd1;
      8'h04: w_fkey_idx = 3'd2;
      8'h0C: w_fkey_idx = 3'd3;
      8'h03: w_fkey_idx = 3'd4;
      8'h0B: w_fkey_idx = 3'd5;
      default: w_fkey_hit = 1'b0;
    endcase
  end

  // Final ADAM code selection
  logic       w_xl_vld;
  logic [7:0] w_xl_code;
  always_comb begin
    w_xl_vld  = 1'b0;
    w_xl_code = 8'h00;
    if (w_s1_ext) begin
      w_xl_vld = 1'b1;
      case (w_s1_code)
        8'h75:   w_xl_code = 8'hA0;
        8'h74:   w_xl_code = 8'hA1;
        8'h72:   w_xl_code = 8'hA2;
        8'h6B:   w_xl_code = 8'hA3;
        default: w_xl_vld  = 1'b0;
      endcase
    end else if (w_letter_hit) begin
      w_xl_vld = 1'b1;
      // ctrl outranks shift/caps
      if (r_ctrl) begin
        w_xl_code = 8'(w_letter_idx) + 8'h01;
      end else if (w_shift ^ r_caps) begin
        w_xl_code = 8'(w_letter_idx) + 8'h41;
      end else begin
        w_xl_code = 8'(w_letter_idx) + 8'h61;
      end
    end else if (w_digit_hit) begin
      w_xl_vld  = 1'b1;
      w_xl_code = w_shift ? w_digit_sh : (8'(w_digit_idx) + 8'h30);
    end else if (w_fkey_hit) begin
      w_xl_vld  = 1'b1;
      w_xl_code = (w_shift ? 8'h89 : 8'h81) + 8'(w_fkey_idx);
    end else begin
      w_xl_vld = 1'b1;
      case (w_s1_code)
        8'h29:   w_xl_code = 8'h20;
        8'h5A:   w_xl_code = 8'h0D;
        8'h66:   w_xl_code = 8'h08;
        8'h0D:   w_xl_code = 8'h09;
        8'h76:   w_xl_code = 8'h1B;
        default: w_xl_vld  = 1'b0;
      endcase
    end
  end

  assign w_s1_push = r_s1_vld & w_s1_press & ~w_is_mod & ~w_repeat & w_xl_vld;

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_shift_l  <= 1'b0;
      r_shift_r  <= 1'b0;
      r_ctrl     <= 1'b0;
      r_caps     <= 1'b0;
      r_held     <= '0;
      r_held_vld <= 1'b0;
      r_s2_vld   <= 1'b0;
      r_s2_code  <= 8'h00;
    end else begin
      r_s2_vld  <= w_s1_push;
      r_s2_code <= w_xl_code;
      if (r_s1_vld) begin
        if (w_is_lshift) r_shift_l <= w_s1_press;
        if (w_is_rshift) r_shift_r <= w_s1_press;
        if (w_is_ctrl)   r_ctrl    <= w_s1_press;
        if (w_is_caps && w_s1_press) r_caps <= ~r_caps;
        // Modifiers never disturb the held-key tracker, so holding shift
        // does not make the next letter look like a repeat.
        if (!w_is_mod) begin
          if (w_s1_press) begin
            r_held     <= w_s1_key;
            r_held_vld <= 1'b1;
          end else if (r_held_vld && (r_held == w_s1_key)) begin
            r_held_vld <= 1'b0;
          end
        end
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: circular FIFO
  // ---------------------------------------------------------------------------
  logic [7:0]            r_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] r_wr_ptr;
  logic [DEPTH_LOG2-1:0] r_rd_ptr;
  logic [DEPTH_LOG2:0]   r_count;
  logic                  r_overflow;

  logic w_empty;
  logic w_full;
  logic w_pop;
  logic w_push;
  logic w_drop;

  assign w_empty = (r_count == '0);
  assign w_full  = (r_count == FULL_LVL);
  assign w_pop   = ~w_empty & key_ready_i;
  // A pop in the same cycle frees the slot, so a push at full still lands.
  assign w_push  = r_s2_vld & (~w_full | w_pop);
  assign w_drop  = r_s2_vld & w_full & ~w_pop;

  // Storage carries no reset; empty gating on the output hides stale data.
  always_ff @(posedge clk_i) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= r_s2_code;
    end
  end

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_overflow <= 1'b0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
      // set beats clear when both happen together
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (overflow_clr_i) begin
        r_overflow <= 1'b0;
      end
    end
  end

  assign key_valid_o = ~w_empty;
  assign key_data_o  = w_empty ? 8'h00 : r_mem[r_rd_ptr];
  assign overflow_o  = r_overflow;
  assign level_o     = r_count;

endmodule

// File: tb/tb_adam_kbd_fifo.sv
module tb_adam_kbd_fifo;

  logic        clk_i = 1'b0;
  logic        reset_n_i = 1'b0;
  logic [10:0] ps2_key = '0;
  logic [7:0]  key_data_o;
  logic        key_valid_o;
  logic        key_ready_i = 1'b0;
  logic        overflow_o;
  logic        overflow_clr_i = 1'b0;
  logic [4:0]  level_o;

  adam_kbd_fifo #(.DEPTH_LOG2(4), .TYPEMATIC(0)) dut (
    .clk_i          (clk_i),
    .reset_n_i      (reset_n_i),
    .ps2_key        (ps2_key),
    .key_data_o     (key_data_o),
    .key_valid_o    (key_valid_o),
    .key_ready_i    (key_ready_i),
    .overflow_o     (overflow_o),
    .overflow_clr_i (overflow_clr_i),
    .level_o        (level_o)
  );

  always #5 clk_i = ~clk_i;

  int n_cmp = 0;
  int n_err = 0;

  // ---------------------------------------------------------------- reference
  // Keyboard tables, indexed by character position
  logic [7:0] letter_sc [26] = '{8'h1C, 8'h32, 8'h21, 8'h23, 8'h24, 8'h2B, 8'h34,
                                  8'h33, 8'h43, 8'h3B, 8'h42, 8'h4B, 8'h3A, 8'h31,
                                  8'h44, 8'h4D, 8'h15, 8'h2D, 8'h1B, 8'h2C, 8'h3C,
                                  8'h2A, 8'h1D, 8'h22, 8'h35, 8'h1A};
  logic [7:0] digit_sc [10]  = '{8'h45, 8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E, 8'h36,
                                  8'h3D, 8'h3E, 8'h46};
  logic [7:0] fkey_sc [6]    = '{8'h05, 8'h06, 8'h04, 8'h0C, 8'h03, 8'h0B};
  string      sh_dig         = ")!@#$%^&*(";

  bit         m_shl, m_shr, m_ctrl, m_caps;
  bit         m_held_vld;
  logic [8:0] m_held;
  bit         exp_ovf;
  logic [7:0] exp_q [$];

  // returns {valid, code}
  function automatic logic [8:0] xlate(input bit ext, input logic [7:0] sc);
    bit sh;
    sh = m_shl | m_shr;
    if (ext) begin
      if (sc == 8'h75) return {1'b1, 8'hA0};
      if (sc == 8'h74) return {1'b1, 8'hA1};
      if (sc == 8'h72) return {1'b1, 8'hA2};
      if (sc == 8'h6B) return {1'b1, 8'hA3};
      return 9'h000;
    end
    for (int i = 0; i < 26; i++)
      if (letter_sc[i] == sc) begin
        if (m_ctrl)        return {1'b1, 8'(i + 1)};
        if (sh != m_caps)  return {1'b1, 8'("A" + i)};
        return {1'b1, 8'("a" + i)};
      end
    for (int d = 0; d < 10; d++)
      if (digit_sc[d] == sc)
        return sh ? {1'b1, sh_dig[d]} : {1'b1, 8'("0" + d)};
    for (int f = 0; f < 6; f++)
      if (fkey_sc[f] == sc)
        return {1'b1, 8'((sh ? 8'h89 : 8'h81) + f)};
    case (sc)
      8'h29: return {1'b1, 8'h20};
      8'h5A: return {1'b1, 8'h0D};
      8'h66: return {1'b1, 8'h08};
      8'h0D: return {1'b1, 8'h09};
      8'h76: return {1'b1, 8'h1B};
      default: return 9'h000;
    endcase
  endfunction

  // Apply one keyboard event to the model; assumes no pops while events flow.
  task automatic model_event(input bit press, input bit ext, input logic [7:0] sc);
    logic [8:0] r;
    if (!ext && sc == 8'h12)      m_shl = press;
    else if (!ext && sc == 8'h59) m_shr = press;
    else if (sc == 8'h14)         m_ctrl = press;
    else if (!ext && sc == 8'h58) begin
      if (press) m_caps = ~m_caps;
    end else if (press) begin
      if (!(m_held_vld && m_held == {ext, sc})) begin
        r = xlate(ext, sc);
        if (r[8]) begin
          if (exp_q.size() < 16) exp_q.push_back(r[7:0]);
          else                   exp_ovf = 1'b1;
        end
      end
      m_held     = {ext, sc};
      m_held_vld = 1'b1;
    end else if (m_held_vld && m_held == {ext, sc}) begin
      m_held_vld = 1'b0;
    end
  endtask

  task automatic model_reset();
    m_shl = 0; m_shr = 0; m_ctrl = 0; m_caps = 0;
    m_held_vld = 0; m_held = '0; exp_ovf = 0;
    exp_q.delete();
  endtask

  // ---------------------------------------------------------------- helpers
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic send(input bit press, input bit ext, input logic [7:0] sc);
    ps2_key = {~ps2_key[10], press, ext, sc};
    model_event(press, ext, sc);
    tick();
  endtask

  task automatic tap(input bit ext, input logic [7:0] sc);
    send(1'b1, ext, sc);
    send(1'b0, ext, sc);
  endtask

  task automatic settle();
    repeat (4) tick();
  endtask

  task automatic drain_check(input string tag);
    int n;
    logic [7:0] e;
    check({tag, "_level"}, 32'(level_o), 32'(exp_q.size()));
    check({tag, "_ovf"}, 32'(overflow_o), 32'(exp_ovf));
    n = exp_q.size();
    for (int i = 0; i < n; i++) begin
      e = exp_q.pop_front();
      check({tag, "_valid"}, 32'(key_valid_o), 32'd1);
      check({tag, "_data"}, 32'(key_data_o), 32'(e));
      key_ready_i = 1'b1;
      tick();
      key_ready_i = 1'b0;
    end
    check({tag, "_empty"}, 32'(key_valid_o), 32'd0);
  endtask

  function automatic logic [8:0] rand_key();
    int k;
    k = $urandom_range(0, 9);
    case (k)
      0, 1, 2, 3: return {1'b0, letter_sc[$urandom_range(0, 5)]};
      4: return {1'b0, digit_sc[$urandom_range(0, 9)]};
      5: case ($urandom_range(0, 4))
           0: return 9'h012;
           1: return 9'h059;
           2: return 9'h014;
           3: return 9'h114;
           default: return 9'h058;
         endcase
      6: case ($urandom_range(0, 4))
           0: return 9'h029;
           1: return 9'h05A;
           2: return 9'h066;
           3: return 9'h00D;
           default: return 9'h076;
         endcase
      7: case ($urandom_range(0, 3))
           0: return 9'h175;
           1: return 9'h174;
           2: return 9'h172;
           default: return 9'h16B;
         endcase
      8: case ($urandom_range(0, 2))
           0: return 9'h07E;
           1: return 9'h11C;
           default: return 9'h112;
         endcase
      default: return {1'b0, fkey_sc[$urandom_range(0, 5)]};
    endcase
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  // ---------------------------------------------------------------- stimulus
  initial begin
    logic [8:0] k;
    int n_ev;
    model_reset();
    repeat (3) tick();
    check("rst_valid", 32'(key_valid_o), 32'd0);
    check("rst_data", 32'(key_data_o), 32'd0);
    check("rst_level", 32'(level_o), 32'd0);
    check("rst_ovf", 32'(overflow_o), 32'd0);
    reset_n_i = 1'b1;
    tick();

    // latency of a single 'a'
    ps2_key = {~ps2_key[10], 1'b1, 1'b0, 8'h1C};
    model_event(1'b1, 1'b0, 8'h1C);
    tick();
    tick();
    check("lat2_valid", 32'(key_valid_o), 32'd0);
    tick();
    check("lat3_valid", 32'(key_valid_o), 32'd1);
    check("lat3_data", 32'(key_data_o), 32'h61);
    check("lat3_level", 32'(level_o), 32'd1);
    send(1'b0, 1'b0, 8'h1C);
    settle();
    drain_check("first");

    // shift, caps lock
    send(1'b1, 1'b0, 8'h12);
    tap(1'b0, 8'h1C);
    send(1'b0, 1'b0, 8'h12);
    tap(1'b0, 8'h1C);
    tap(1'b0, 8'h58);
    tap(1'b0, 8'h1C);
    tap(1'b0, 8'h58);
    settle();
    check("shift_head", 32'(key_data_o), 32'h41);
    drain_check("shift");

    // ctrl, arrow, unknown
    send(1'b1, 1'b0, 8'h14);
    tap(1'b0, 8'h21);
    send(1'b0, 1'b0, 8'h14);
    tap(1'b1, 8'h75);
    tap(1'b0, 8'h7E);
    settle();
    check("ctrl_head", 32'(key_data_o), 32'h03);
    drain_check("ctrl");

    // repeat suppression
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h1C);
    send(1'b1, 1'b0, 8'h1C);
    settle();
    check("rep_level", 32'(level_o), 32'd1);
    send(1'b0, 1'b0, 8'h1C);
    tap(1'b0, 8'h1C);
    settle();
    drain_check("repeat");

    // fill past full
    for (int i = 0; i < 17; i++) tap(1'b0, letter_sc[i]);
    settle();
    check("full_level", 32'(level_o), 32'd16);
    check("full_ovf", 32'(overflow_o), 32'd1);
    overflow_clr_i = 1'b1;
    tick();
    overflow_clr_i = 1'b0;
    check("ovf_clr", 32'(overflow_o), 32'd0);
    exp_ovf = 1'b0;
    // push and pop land on the same edge at full
    check("pp_head", 32'(key_data_o), 32'(exp_q[0]));
    void'(exp_q.pop_front());
    send(1'b1, 1'b0, 8'h1A);
    tick();
    key_ready_i = 1'b1;
    tick();
    key_ready_i = 1'b0;
    check("pp_level", 32'(level_o), 32'd16);
    check("pp_ovf", 32'(overflow_o), 32'd0);
    send(1'b0, 1'b0, 8'h1A);
    settle();
    drain_check("fill");

    // asynchronous reset mid-stream
    for (int i = 0; i < 5; i++) tap(1'b0, letter_sc[i]);
    settle();
    check("pre_rst_level", 32'(level_o), 32'd5);
    #2;
    reset_n_i = 1'b0;
    ps2_key   = {1'b1, 1'b1, 1'b0, 8'h32};
    #1;
    check("arst_valid", 32'(key_valid_o), 32'd0);
    check("arst_level", 32'(level_o), 32'd0);
    tick();
    tick();
    reset_n_i = 1'b1;
    model_reset();
    settle();
    check("phantom_level", 32'(level_o), 32'd0);
    tap(1'b0, 8'h1C);
    settle();
    drain_check("post_rst");

    // randomized rounds
    for (int r = 0; r < 30; r++) begin
      n_ev = $urandom_range(1, 30);
      for (int e = 0; e < n_ev; e++) begin
        k = rand_key();
        send(($urandom_range(0, 9) < 7), k[8], k[7:0]);
        if ($urandom_range(0, 3) == 0) tick();
      end
      settle();
      drain_check("rand");
      if (exp_ovf) begin
        overflow_clr_i = 1'b1;
        tick();
        overflow_clr_i = 1'b0;
        check("rand_ovf_clr", 32'(overflow_o), 32'd0);
        exp_ovf = 1'b0;
      end
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
